// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared definitions for the obstacle scheduler.
// Holds the scheduler state encoding, the drawer select codes and the
// default timing values used by obstacle_scheduler.
package obstacle_pkg;

  // Scheduler states; the encoding is shared with anything that decodes it.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_WON    = 3'd4,
    ST_LOST   = 3'd5
  } state_e;

  // Select codes; each drawer's SELECT_CODE parameter must match one of these.
  localparam logic [3:0] CODE_OBST_0 = 4'd0;
  localparam logic [3:0] CODE_OBST_1 = 4'd1;
  localparam logic [3:0] CODE_OBST_2 = 4'd2;
  localparam logic [3:0] CODE_OBST_3 = 4'd3;

  // Default timing, in clock cycles.
  localparam int DEFAULT_GAP_CYCLES     = 1000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr: 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running.
// Used by obstacle_scheduler only when OBSTACLE_SCHED_RANDOM_ORDER_EN is defined.
module obstacle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  // Next LFSR value: shift left, feed back the XOR of taps 8,6,5,4.
  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = {lfsr_q[6:0], feedback};
  end

  // Advance every cycle; synchronous reset reloads the seed.
  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: picks the next obstacle drawer, emits a one-cycle
// start pulse, waits for that drawer's done (or a watchdog timeout), counts
// rounds and raises win/lose flags.
// Build option: define OBSTACLE_SCHED_RANDOM_ORDER_EN for LFSR-driven order
// with no back-to-back repeats; otherwise obstacles run in round order.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int         NUM_OBSTACLES  = 4,
  parameter int         ROUNDS         = 8,
  parameter int         GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     play_selected,
  input  logic                     menu_on,
  input  logic                     player_hit,
  input  logic [NUM_OBSTACLES-1:0] obstacle_done,
  output logic [3:0]               selected,
  output logic                     start,
  output logic                     game_on,
  output logic [3:0]               round,
  output logic                     game_won,
  output logic                     game_lost,
  output logic                     timeout_err
);

  localparam int              GW           = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST     = GW'(GAP_CYCLES - 1);
  localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      CODE_MASK    = 4'(NUM_OBSTACLES - 1);
  localparam logic [3:0]      ROUNDS_L     = 4'(ROUNDS);

  // Elaboration-time parameter sanity checks.
  if (NUM_OBSTACLES < 1 || NUM_OBSTACLES > 16 ||
      (NUM_OBSTACLES & (NUM_OBSTACLES - 1)) != 0) begin : g_bad_num
    $error("NUM_OBSTACLES must be a power of two in 1..16");
  end
  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("ROUNDS must be in 1..15");
  end
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
    $error("GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  state_e        state_q, state_d;
  logic [3:0]    selected_q, selected_d;
  logic          start_q, start_d;
  logic          game_on_q, game_on_d;
  logic [3:0]    round_q, round_d;
  logic          game_won_q, game_won_d;
  logic          game_lost_q, game_lost_d;
  logic          timeout_err_q, timeout_err_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]   to_cnt_q, to_cnt_d;

  logic       abort;
  logic       done_sel;
  logic [3:0] round_inc;
  logic [3:0] next_code;

  assign abort = menu_on | ~play_selected;

  // Pick out the done bit belonging to the running obstacle; others are ignored.
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (selected_q == 4'(i)) done_sel = obstacle_done[i];
    end
  end

`ifdef OBSTACLE_SCHED_RANDOM_ORDER_EN
  logic [7:0] lfsr_value;
  logic [3:0] rand_code;
  logic [3:0] prev_code_q, prev_code_d;

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  // Random code from the LFSR, bumped by one if it would repeat the last obstacle.
  always_comb begin
    rand_code = lfsr_value[3:0] & CODE_MASK;
    if (NUM_OBSTACLES > 1 && rand_code == prev_code_q) begin
      next_code = (rand_code + 4'd1) & CODE_MASK;
    end else begin
      next_code = rand_code;
    end
    prev_code_d = (state_q == ST_GAP && state_d == ST_LAUNCH) ? selected_d : prev_code_q;
  end

  // Remember the last launched code so it is not chosen twice in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code_q <= CODE_OBST_0;
    end else begin
      prev_code_q <= prev_code_d;
    end
  end
`else
  // Sequential order: the round count picks the drawer.
  always_comb begin
    next_code = round_q & CODE_MASK;
  end
`endif

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    selected_d    = selected_q;
    round_d       = round_q;
    timeout_err_d = timeout_err_q;
    gap_cnt_d     = gap_cnt_q;
    to_cnt_d      = to_cnt_q;
    round_inc     = round_q + 4'd1;

    if (state_q != ST_IDLE && abort) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          gap_cnt_d = '0;
          to_cnt_d  = '0;
          if (play_selected && !menu_on) begin
            round_d       = 4'd0;
            timeout_err_d = 1'b0;
            state_d       = ST_GAP;
          end
        end
        ST_GAP: begin
          if (player_hit) begin
            state_d = ST_LOST;
          end else if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d  = '0;
            selected_d = next_code;
            state_d    = ST_LAUNCH;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        ST_LAUNCH: begin
          to_cnt_d = '0;
          state_d  = player_hit ? ST_LOST : ST_RUN;
        end
        ST_RUN: begin
          if (player_hit) begin
            state_d = ST_LOST;
          end else if (done_sel || to_cnt_q == TIMEOUT_LAST) begin
            // A watchdog expiry completes the round just like a done.
            if (!done_sel) timeout_err_d = 1'b1;
            round_d   = round_inc;
            to_cnt_d  = '0;
            gap_cnt_d = '0;
            state_d   = (round_inc == ROUNDS_L) ? ST_WON : ST_GAP;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
        ST_WON, ST_LOST: begin
          state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state, so they line up with it.
    start_d     = (state_d == ST_LAUNCH);
    game_on_d   = (state_d inside {ST_GAP, ST_LAUNCH, ST_RUN});
    game_won_d  = (state_d == ST_WON);
    game_lost_d = (state_d == ST_LOST);
    if (state_d == ST_IDLE) timeout_err_d = 1'b0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      selected_q    <= CODE_OBST_0;
      start_q       <= 1'b0;
      game_on_q     <= 1'b0;
      round_q       <= 4'd0;
      game_won_q    <= 1'b0;
      game_lost_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      selected_q    <= selected_d;
      start_q       <= start_d;
      game_on_q     <= game_on_d;
      round_q       <= round_d;
      game_won_q    <= game_won_d;
      game_lost_q   <= game_lost_d;
      timeout_err_q <= timeout_err_d;
      gap_cnt_q     <= gap_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign selected    = selected_q;
  assign start       = start_q;
  assign game_on     = game_on_q;
  assign round       = round_q;
  assign game_won    = game_won_q;
  assign game_lost   = game_lost_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: self-checking bench for obstacle_scheduler.
// Expected launch codes are queued as games are started and compared when
// the scheduler emits each start pulse.
module tb_obstacle_scheduler;

  localparam int NUM = 4;
  localparam int GAP = 4;
  localparam int TMO = 50;
`ifdef OBSTACLE_SCHED_RANDOM_ORDER_EN
  localparam int ROUNDS = 15;
`else
  localparam int ROUNDS = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           play_selected;
  logic           menu_on;
  logic           player_hit;
  logic [NUM-1:0] obstacle_done;
  logic [3:0]     selected;
  logic           start;
  logic           game_on;
  logic [3:0]     round;
  logic           game_won;
  logic           game_lost;
  logic           timeout_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_sel_q[$];
  logic [3:0] seen_q[$];
  logic [3:0] first_seq[$];

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .NUM_OBSTACLES  (NUM),
    .ROUNDS         (ROUNDS),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play_selected (play_selected),
    .menu_on       (menu_on),
    .player_hit    (player_hit),
    .obstacle_done (obstacle_done),
    .selected      (selected),
    .start         (start),
    .game_on       (game_on),
    .round         (round),
    .game_won      (game_won),
    .game_lost     (game_lost),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: every start pulse is matched against the next queued code.
  always @(negedge clk) begin
    if (start) begin
      seen_q.push_back(selected);
`ifndef OBSTACLE_SCHED_RANDOM_ORDER_EN
      check("start_expected", 32'(exp_sel_q.size() > 0), 1);
      if (exp_sel_q.size() > 0) check("start_selected", 32'(selected), 32'(exp_sel_q.pop_front()));
`endif
    end
  end

  task automatic do_reset();
    rst = 1'b1; play_selected = 1'b0; menu_on = 1'b0;
    player_hit = 1'b0; obstacle_done = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a start pulse; reports how many gap cycles preceded it.
  task automatic wait_start(output int waited);
    waited = 0;
    while (!start && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("start_seen", 32'(start), 1);
  endtask

  // Called on the start cycle: pulse the running obstacle's done 'delay' cycles later.
  task automatic pulse_done(input int delay);
    repeat (delay) @(negedge clk);
    obstacle_done = '0;
    obstacle_done[selected[1:0]] = 1'b1;
    @(negedge clk);
    obstacle_done = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    do_reset();
    check("rst_selected", 32'(selected), 0);
    check("rst_start", 32'(start), 0);
    check("rst_game_on", 32'(game_on), 0);
    check("rst_round", 32'(round), 0);
    check("rst_flags", {29'd0, game_won, game_lost, timeout_err}, 0);

`ifndef OBSTACLE_SCHED_RANDOM_ORDER_EN
    // Normal game: sequential codes 0,1,2, done 10 cycles after each start.
    for (int i = 0; i < ROUNDS; i++) exp_sel_q.push_back(4'(i));
    play_selected = 1'b1;
    @(negedge clk);
    check("gap_game_on", 32'(game_on), 1);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_start(w);
      check("gap_len", 32'(w), GAP);
      @(negedge clk);
      check("start_one_cycle", 32'(start), 0);
      check("run_selected", 32'(selected), 32'(r));
      pulse_done(9);
      check("round_after_done", 32'(round), 32'(r + 1));
      check("game_on_after_done", 32'(game_on), (r == ROUNDS - 1) ? 0 : 1);
    end
    check("won_set", 32'(game_won), 1);
    repeat (5) @(negedge clk);
    check("won_held", 32'(game_won), 1);
    check("won_round", 32'(round), 3);
    play_selected = 1'b0;
    @(negedge clk);
    check("won_cleared", 32'(game_won), 0);
    check("idle_game_on", 32'(game_on), 0);

    // Hit in the second RUN: lose, round frozen, no further launch.
    exp_sel_q.push_back(4'd0);
    exp_sel_q.push_back(4'd1);
    play_selected = 1'b1;
    @(negedge clk);
    wait_start(w);
    pulse_done(10);
    wait_start(w);
    repeat (3) @(negedge clk);
    player_hit = 1'b1;
    @(negedge clk);
    player_hit = 1'b0;
    check("hit_lost", 32'(game_lost), 1);
    check("hit_round", 32'(round), 1);
    check("hit_game_on", 32'(game_on), 0);
    repeat (20) @(negedge clk);
    check("lost_held", 32'(game_lost), 1);
    play_selected = 1'b0;
    @(negedge clk);
    check("lost_cleared", 32'(game_lost), 0);

    // Abort in the LAUNCH cycle, then restart from a clean state.
    exp_sel_q.push_back(4'd0);
    play_selected = 1'b1;
    @(negedge clk);
    wait_start(w);
    menu_on = 1'b1;
    @(negedge clk);
    check("abort_start", 32'(start), 0);
    check("abort_game_on", 32'(game_on), 0);
    menu_on = 1'b0;
    @(negedge clk);
    check("restart_game_on", 32'(game_on), 1);
    check("restart_round", 32'(round), 0);
    check("restart_flags", {29'd0, game_won, game_lost, timeout_err}, 0);

    // Wrong done ignored, then a watchdog timeout completes round 2.
    exp_sel_q.push_back(4'd0);
    exp_sel_q.push_back(4'd1);
    exp_sel_q.push_back(4'd2);
    wait_start(w);
    check("gap_len_restart", 32'(w), GAP);
    pulse_done(10);
    wait_start(w);
    for (int k = 1; k <= TMO + 1; k++) begin
      @(negedge clk);
      if (k == 5) obstacle_done = 4'b1001;
      if (k == 6) begin
        obstacle_done = '0;
        check("wrong_done_round", 32'(round), 1);
        check("wrong_done_run", {30'd0, game_on, start}, 32'b10);
      end
      if (k == TMO) begin
        check("tmo_not_early", 32'(round), 1);
        check("tmo_err_not_early", 32'(timeout_err), 0);
      end
    end
    check("tmo_round", 32'(round), 2);
    check("tmo_err", 32'(timeout_err), 1);
    wait_start(w);
    check("tmo_gap_len", 32'(w), GAP);
    pulse_done(10);
    check("tmo_game_won", 32'(game_won), 1);
    check("tmo_err_sticky", 32'(timeout_err), 1);
    play_selected = 1'b0;
    @(negedge clk);
    check("idle_tmo_err", 32'(timeout_err), 0);

    // Reset mid-game right before a launch: everything returns to reset values.
    exp_sel_q.push_back(4'd0);
    play_selected = 1'b1;
    @(negedge clk);
    wait_start(w);
    pulse_done(10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_start", 32'(start), 0);
    check("midrst_round", 32'(round), 0);
    check("midrst_game_on", 32'(game_on), 0);
    check("midrst_selected", 32'(selected), 0);
    play_selected = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_sel_q.size()), 0);
`else
    // Random order: record two games from identical resets and compare.
    for (int g = 0; g < 2; g++) begin
      if (g == 1) do_reset();
      seen_q.delete();
      play_selected = 1'b1;
      @(negedge clk);
      for (int r = 0; r < ROUNDS; r++) begin
        wait_start(w);
        pulse_done(2);
      end
      check("rand_won", 32'(game_won), 1);
      check("rand_count", 32'(seen_q.size()), ROUNDS);
      for (int i = 0; i < seen_q.size(); i++) begin
        check("rand_range", 32'(seen_q[i] < 4'd4), 1);
        if (i > 0) check("rand_no_repeat", 32'(seen_q[i] != seen_q[i-1]), 1);
      end
      play_selected = 1'b0;
      @(negedge clk);
      if (g == 0) first_seq = seen_q;
    end
    check("rand_len_match", 32'(seen_q.size()), 32'(first_seq.size()));
    for (int i = 0; i < seen_q.size() && i < first_seq.size(); i++) begin
      check("rand_repeatable", 32'(seen_q[i]), 32'(first_seq[i]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Sequences the game-phase obstacle modules.
- Chooses which obstacle runs next, drives the shared selected code and a one-cycle start pulse, and waits for that obstacle's done.
- Counts completed rounds, inserts a gap between obstacles, and raises win/lose flags.
- Sits between the menu/control logic and the bank of obstacle drawers; its start output feeds each drawer's done_in and its selected output feeds each drawer's selected input.

Parameters:
- NUM_OBSTACLES, 4: number of obstacle drawers. Power of two, 1..16. Drawer codes are 0..NUM_OBSTACLES-1.
- ROUNDS, 8: obstacles to complete for a win. Range 1..15.
- GAP_CYCLES, 1000: idle cycles before each launch, including the first. Must be ≥1.
- TIMEOUT_CYCLES, 2000000: watchdog limit in RUN, in cycles.
- LFSR_SEED, 8'hA5: reset value of the random generator. Must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- play_selected  in  1  player chose play; must stay high for the whole game
- menu_on  in  1  menu displayed; aborts the game
- player_hit  in  1  collision detected this cycle
- obstacle_done  in  NUM_OBSTACLES  done pulses from the drawers; bit i belongs to code i
- selected  out  4  code of the current or next obstacle
- start  out  1  one-cycle launch pulse, fed to the drawers' done_in
- game_on  out  1  high in GAP, LAUNCH and RUN
- round  out  4  number of completed obstacles
- game_won  out  1  sticky win flag
- game_lost  out  1  sticky lose flag
- timeout_err  out  1  sticky flag: at least one obstacle timed out this game

Behaviour:
- All outputs are registered. Reset values: selected=0, start=0, game_on=0, round=0, game_won=0, game_lost=0, timeout_err=0, state=IDLE, gap/timeout counters=0, LFSR=LFSR_SEED, prev_code=0.
- abort = menu_on OR NOT play_selected. Evaluated every cycle in every non-IDLE state.
- Priority each cycle: abort > player_hit > done > timeout.
- IDLE:
  - All flags stay clear; counters are cleared.
  - If play_selected=1 and menu_on=0: clear round, clear timeout_err, go to GAP.
- GAP:
  - The gap counter increments from 0.
  - When it reaches GAP_CYCLES-1: latch next_code into selected, latch it into prev_code, clear the counter, go to LAUNCH.
  - A GAP therefore lasts exactly GAP_CYCLES cycles.
- LAUNCH:
  - Lasts exactly one cycle; start=1 in that cycle only. selected is already stable and stays stable through the end of RUN.
  - Next state is RUN. The timeout counter is cleared.
- RUN:
  - The timeout counter increments each cycle.
  - If obstacle_done[selected]=1: round ← round+1. If round+1 == ROUNDS, go to WON; otherwise go to GAP.
  - Done bits of non-selected obstacles are ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: handle exactly as a done (round increments) and set timeout_err.
- player_hit=1 in GAP, LAUNCH or RUN: go to LOST. round is frozen.
- WON: game_won=1, game_on=0. Held until abort, then go to IDLE.
- LOST: game_lost=1, game_on=0. Held until abort, then go to IDLE.
- Abort in any state: go to IDLE next cycle.
  - start is forced to 0 in the abort cycle, even if abort occurs in LAUNCH.
  - game_won/game_lost clear on entry to IDLE.
- Default next_code (sequential order): round mod NUM_OBSTACLES, computed from the round value at GAP exit.
- Reset mid-game: every register returns to its reset value the following cycle; no start is emitted.
- Arithmetic:
  - round is a 4-bit counter and never wraps, because ROUNDS ≤ 15.
  - The timeout counter is 32 bits.
  - The gap counter is wide enough for GAP_CYCLES.

Optional Feature:
- Macro: OBSTACLE_SCHED_RANDOM_ORDER_EN.
- Defined:
  - next_code = lfsr[log2(NUM_OBSTACLES)-1:0].
  - The LFSR is an 8-bit Fibonacci register with taps 8,6,5,4. It advances every cycle when not in reset.
  - If next_code == prev_code and NUM_OBSTACLES > 1, use (next_code+1) mod NUM_OBSTACLES instead. No obstacle repeats back-to-back.
- Undefined: sequential order as above, and no LFSR logic is synthesised.

Decomposition:
- Shared package obstacle_pkg holds:
  - the state encoding (IDLE, GAP, LAUNCH, RUN, WON, LOST)
  - the obstacle code constants that match each drawer's SELECT_CODE
  - default GAP_CYCLES and TIMEOUT_CYCLES values
- One sub-module, obstacle_lfsr: 8-bit LFSR with clk, rst, SEED parameter and an 8-bit value output. It is instantiated only under the macro.

Test Plan:
- Normal game: rst; play_selected=1, menu_on=0, GAP_CYCLES=4, ROUNDS=3, sequential; pulse obstacle_done[selected] 10 cycles after each start.
  - Expect start high exactly 1 cycle after each 4-cycle gap.
  - Expect selected sequence 0,1,2.
  - Expect round 1,2,3 and game_won=1; game_won stays set until play_selected=0, then returns to IDLE.
- Hit: after the first done, assert player_hit for 1 cycle in the second RUN.
  - Expect game_lost=1 next cycle, round=1, no further start.
- Abort during LAUNCH: menu_on=1 in the LAUNCH cycle.
  - Expect start=0 and IDLE next cycle.
  - Expect all flags 0 and round=0 after restart.
- Timeout: TIMEOUT_CYCLES=50, never pulse done.
  - Expect round to increment 50 cycles after start, timeout_err=1, next launch after the gap.
- Wrong done: pulse the done bit for code 3 while selected=1.
  - Expect no state change; the scheduler stays in RUN.
- Random mode (macro defined, NUM_OBSTACLES=4, ROUNDS=15, seed A5): record selected over the game.
  - Expect no two consecutive codes equal.
  - Expect all codes <4.
  - Expect the sequence identical across two resets.
